// File: rtl/mpc_types.sv
// Shared geometry, types and small combinational helpers for the return crossbar control.
package mpc_types;

  localparam int RTN_NBANK  = 4;
  localparam int RTN_NCH    = 3;
  localparam int RTN_NENTRY = 8;

  typedef logic [2:0] rtnEntry_t;
  typedef logic [1:0] rtnCh_t;

  typedef struct packed {
    logic [7:0] rsvd;
  } mpc_cfg_t;

  // Lowest free entry; falls back to 0 when every entry is taken.
  function automatic rtnEntry_t first_free(input logic [RTN_NENTRY-1:0] ev);
    rtnEntry_t idx;
    idx = 3'd0;
    for (int i = RTN_NENTRY - 1; i >= 0; i--) begin
      idx = ev[i] ? idx : rtnEntry_t'(i);
    end
    return idx;
  endfunction

  // Round-robin pick starting just after the last granted bank.
  function automatic logic [RTN_NBANK-1:0] rr_grant(input logic [RTN_NBANK-1:0] req,
                                                    input logic [1:0] last);
    logic [RTN_NBANK-1:0] gnt;
    logic [1:0]           idx;
    gnt = 4'b0000;
    for (int k = RTN_NBANK; k >= 1; k--) begin
      idx = last + 2'(k);
      gnt = req[idx] ? (4'b0001 << idx) : gnt;
    end
    return gnt;
  endfunction

  function automatic logic [1:0] oh_to_idx(input logic [RTN_NBANK-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < RTN_NBANK; i++) begin
      idx = oh[i] ? 2'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rtn_xbar_ctrl_bank.sv
// Per-bank allocator: entry-valid vector, occupancy and three per-channel entry-index FIFOs.
module rtn_xbar_ctrl_bank
  import mpc_types::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           hs,
  input  rtnCh_t                         ch_id,
  input  logic [RTN_NCH-1:0]             pop,
  output logic                           ready,
  output rtnEntry_t                      w_ptr,
  output logic [RTN_NCH-1:0]             nonempty,
  output logic [RTN_NCH*RTN_NENTRY-1:0]  head_1hot
);

  logic [RTN_NENTRY-1:0] ev_r;
  logic [RTN_NENTRY-1:0] set_s;
  logic [RTN_NENTRY-1:0] clr_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_nxt_s;
  logic [1:0]            npop_s;
  logic                  alloc_s;
  logic [RTN_NCH-1:0]    push_s;
  rtnEntry_t             mem_r  [RTN_NCH][RTN_NENTRY];
  rtnEntry_t             rd_r   [RTN_NCH];
  rtnEntry_t             wr_r   [RTN_NCH];
  logic [3:0]            fcnt_r [RTN_NCH];

  // Channel id 3 completes the handshake but allocates nothing.
  assign ready   = (cnt_r != 4'd8);
  assign w_ptr   = first_free(ev_r);
  assign alloc_s = hs && (ch_id != 2'd3);

  // FIFO heads presented to the arbiters, from registered state only.
  always_comb begin
    for (int j = 0; j < RTN_NCH; j++) begin
      nonempty[j] = (fcnt_r[j] != 4'd0);
      head_1hot[j*RTN_NENTRY +: RTN_NENTRY] = nonempty[j] ? (8'd1 << mem_r[j][rd_r[j]]) : 8'd0;
    end
  end

  // Next-state terms for allocation and release.
  always_comb begin
    clr_s  = 8'd0;
    npop_s = 2'd0;
    for (int j = 0; j < RTN_NCH; j++) begin
      push_s[j] = alloc_s && (ch_id == rtnCh_t'(j));
      clr_s     = clr_s | (pop[j] ? (8'd1 << mem_r[j][rd_r[j]]) : 8'd0);
      npop_s    = npop_s + {1'b0, pop[j]};
    end
    set_s     = alloc_s ? (8'd1 << w_ptr) : 8'd0;
    cnt_nxt_s = cnt_r + {3'd0, alloc_s} - {2'd0, npop_s};
  end

  // Occupancy and FIFO pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_r  <= 8'd0;
      cnt_r <= 4'd0;
      for (int j = 0; j < RTN_NCH; j++) begin
        rd_r[j]   <= 3'd0;
        wr_r[j]   <= 3'd0;
        fcnt_r[j] <= 4'd0;
      end
    end else begin
      ev_r  <= (ev_r & ~clr_s) | set_s;
      cnt_r <= cnt_nxt_s;
      for (int j = 0; j < RTN_NCH; j++) begin
        rd_r[j]   <= rd_r[j] + {2'd0, pop[j]};
        wr_r[j]   <= wr_r[j] + {2'd0, push_s[j]};
        fcnt_r[j] <= fcnt_r[j] + {3'd0, push_s[j]} - {3'd0, pop[j]};
      end
    end
  end

  // FIFO storage; contents are only meaningful behind a non-zero count.
  always_ff @(posedge clk) begin
    for (int j = 0; j < RTN_NCH; j++) begin
      if (push_s[j]) begin
        mem_r[j][wr_r[j]] <= w_ptr;
      end
    end
  end

`ifdef RTN_XBAR_CTRL_ASSERT_EN
  a_no_ch3:   assert property (@(posedge clk) disable iff (!rst_n) hs |-> (ch_id != 2'd3));
  a_cnt_max:  assert property (@(posedge clk) disable iff (!rst_n) cnt_r <= 4'd8);
  a_ev_cnt:   assert property (@(posedge clk) disable iff (!rst_n) $countones(ev_r) == int'(cnt_r));
  a_rel_live: assert property (@(posedge clk) disable iff (!rst_n) (clr_s & ~ev_r) == 8'd0);
`endif

endmodule

// File: rtl/rtn_xbar_ctrl.sv
// Return crossbar control top: per-bank allocators plus one round-robin arbiter per channel.
// Optional SVA checks are compiled in with RTN_XBAR_CTRL_ASSERT_EN.
module rtn_xbar_ctrl
  import mpc_types::*;
(
  input  mpc_cfg_t     Cfg,
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   d_bank_rsp_valid,
  input  logic [7:0]   d_bank_rsp_channel_id,
  output logic [3:0]   d_bank_rsp_ready,
  output logic [11:0]  bank_w_ptr,
  input  logic [2:0]   u_ch_rsp_ready,
  output logic [2:0]   u_ch_rsp_valid,
  output logic [11:0]  ch_bank_1hot_id,
  output logic [95:0]  bank_ch_r_entry_1hot_id
);

  logic [RTN_NCH-1:0]   nonempty_s [RTN_NBANK];
  logic [RTN_NCH-1:0]   pop_s      [RTN_NBANK];
  logic [RTN_NBANK-1:0] req_s      [RTN_NCH];
  logic [RTN_NBANK-1:0] gnt_s      [RTN_NCH];
  logic [1:0]           last_r     [RTN_NCH];
  logic [RTN_NCH-1:0]   cs_s;
  logic                 unused_cfg_s;

  assign unused_cfg_s = ^Cfg;

  for (genvar b = 0; b < RTN_NBANK; b++) begin : g_bank
    rtn_xbar_ctrl_bank u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .hs        (d_bank_rsp_valid[b] & d_bank_rsp_ready[b]),
      .ch_id     (d_bank_rsp_channel_id[2*b +: 2]),
      .pop       (pop_s[b]),
      .ready     (d_bank_rsp_ready[b]),
      .w_ptr     (bank_w_ptr[3*b +: 3]),
      .nonempty  (nonempty_s[b]),
      .head_1hot (bank_ch_r_entry_1hot_id[24*b +: 24])
    );
  end

  // Channel arbitration; valid is independent of the channel's ready.
  always_comb begin
    for (int j = 0; j < RTN_NCH; j++) begin
      for (int b = 0; b < RTN_NBANK; b++) begin
        req_s[j][b] = nonempty_s[b][j];
      end
      gnt_s[j]                  = rr_grant(req_s[j], last_r[j]);
      u_ch_rsp_valid[j]         = |req_s[j];
      ch_bank_1hot_id[4*j +: 4] = gnt_s[j];
      cs_s[j]                   = u_ch_rsp_valid[j] & u_ch_rsp_ready[j];
    end
    for (int b = 0; b < RTN_NBANK; b++) begin
      for (int j = 0; j < RTN_NCH; j++) begin
        pop_s[b][j] = cs_s[j] & gnt_s[j][b];
      end
    end
  end

  // Last-grant pointers start at bank 3 so bank 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < RTN_NCH; j++) begin
        last_r[j] <= 2'd3;
      end
    end else begin
      for (int j = 0; j < RTN_NCH; j++) begin
        if (cs_s[j]) begin
          last_r[j] <= oh_to_idx(gnt_s[j]);
        end
      end
    end
  end

`ifdef RTN_XBAR_CTRL_ASSERT_EN
  for (genvar j = 0; j < RTN_NCH; j++) begin : g_gnt_chk
    a_gnt_oh: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_s[j]));
  end
`endif

endmodule

// File: tb/tb_rtn_xbar_ctrl.sv
// Self-checking bench for rtn_xbar_ctrl against a queue-based reference model.
module tb_rtn_xbar_ctrl;
  import mpc_types::*;

  logic        clk;
  logic        rst_n;
  mpc_cfg_t    cfg;
  logic [3:0]  bank_valid;
  logic [7:0]  bank_ch;
  logic [3:0]  bank_ready;
  logic [11:0] w_ptr;
  logic [2:0]  ch_ready;
  logic [2:0]  ch_valid;
  logic [11:0] ch_gnt;
  logic [95:0] r_entry;

  int n_checks;
  int n_fails;

  // Reference model: occupied entries, per-(bank,channel) arrival queues, last grant per channel.
  bit used [4][8];
  int q    [4][3][$];
  int last [3];

  rtn_xbar_ctrl dut (
    .Cfg                     (cfg),
    .clk                     (clk),
    .rst_n                   (rst_n),
    .d_bank_rsp_valid        (bank_valid),
    .d_bank_rsp_channel_id   (bank_ch),
    .d_bank_rsp_ready        (bank_ready),
    .bank_w_ptr              (w_ptr),
    .u_ch_rsp_ready          (ch_ready),
    .u_ch_rsp_valid          (ch_valid),
    .ch_bank_1hot_id         (ch_gnt),
    .bank_ch_r_entry_1hot_id (r_entry)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) used[b][i] = 1'b0;
      for (int j = 0; j < 3; j++) q[b][j].delete();
    end
    for (int j = 0; j < 3; j++) last[j] = 3;
  endtask

  // Called just after a falling edge: check outputs, drive inputs, advance the model one cycle.
  task automatic step(input logic [3:0] v, input logic [7:0] ch, input logic [2:0] cr);
    logic [3:0]  e_rdy;
    logic [11:0] e_wp;
    logic [2:0]  e_val;
    logic [11:0] e_gnt;
    logic [95:0] e_re;
    int gb [3];
    int occ, fp, c, e, b;
    e_rdy = '0; e_wp = '0; e_val = '0; e_gnt = '0; e_re = '0;
    for (int bk = 0; bk < 4; bk++) begin
      occ = 0; fp = -1;
      for (int i = 0; i < 8; i++) begin
        if (used[bk][i]) occ++;
        else if (fp < 0) fp = i;
      end
      e_rdy[bk] = (occ < 8);
      e_wp[3*bk +: 3] = (fp < 0) ? 3'd0 : 3'(fp);
      for (int j = 0; j < 3; j++)
        if (q[bk][j].size() > 0) e_re[8*(3*bk+j) + q[bk][j][0]] = 1'b1;
    end
    for (int j = 0; j < 3; j++) begin
      gb[j] = -1;
      for (int k = 1; k <= 4; k++) begin
        b = (last[j] + k) % 4;
        if (gb[j] < 0 && q[b][j].size() > 0) gb[j] = b;
      end
      if (gb[j] >= 0) begin
        e_val[j] = 1'b1;
        e_gnt[4*j + gb[j]] = 1'b1;
      end
    end
    check_eq("ready",   96'(bank_ready), 96'(e_rdy));
    check_eq("w_ptr",   96'(w_ptr),      96'(e_wp));
    check_eq("valid",   96'(ch_valid),   96'(e_val));
    check_eq("grant",   96'(ch_gnt),     96'(e_gnt));
    check_eq("r_entry", r_entry,         e_re);
    bank_valid = v;
    bank_ch    = ch;
    ch_ready   = cr;
    for (int j = 0; j < 3; j++) begin
      if (gb[j] >= 0 && cr[j]) begin
        e = q[gb[j]][j].pop_front();
        used[gb[j]][e] = 1'b0;
        last[j] = gb[j];
      end
    end
    for (int bk = 0; bk < 4; bk++) begin
      c = int'(ch[2*bk +: 2]);
      if (v[bk] && e_rdy[bk] && c != 3) begin
        e = int'(e_wp[3*bk +: 3]);
        used[bk][e] = 1'b1;
        q[bk][c].push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bank_valid = '0;
    bank_ch    = '0;
    ch_ready   = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ready",   96'(bank_ready), 96'(4'hF));
    check_eq("rst_w_ptr",   96'(w_ptr),      96'(12'h000));
    check_eq("rst_valid",   96'(ch_valid),   96'(3'b000));
    check_eq("rst_grant",   96'(ch_gnt),     96'(12'h000));
    check_eq("rst_r_entry", r_entry,         96'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(4'h0, 8'h00, 3'b111);
  endtask

  initial begin
    logic [7:0] rch;
    logic [2:0] rready;
    clk = 1'b0; rst_n = 1'b1; cfg = '0;
    bank_valid = '0; bank_ch = '0; ch_ready = '0;
    n_checks = 0; n_fails = 0;
    model_clear();
    do_reset();

    // Single response on bank 2 to channel 1.
    step(4'b0100, 8'h10, 3'b000);
    check_eq("single_valid", 96'(ch_valid), 96'(3'b010));
    check_eq("single_grant", 96'(ch_gnt[7:4]), 96'(4'b0100));
    check_eq("single_entry", 96'(r_entry[8*7 +: 8]), 96'(8'h01));
    step(4'b0000, 8'h00, 3'b000);
    step(4'b0000, 8'h00, 3'b010);
    check_eq("single_release", 96'(ch_valid), 96'(3'b000));

    // Fill bank 0 for channel 0, then one release and refill.
    for (int i = 0; i < 9; i++) step(4'b0001, 8'h00, 3'b000);
    check_eq("fill_ready0", 96'(bank_ready[0]), 96'(1'b0));
    step(4'b0000, 8'h00, 3'b001);
    check_eq("refill_ready0", 96'(bank_ready[0]), 96'(1'b1));
    check_eq("refill_wptr0", 96'(w_ptr[2:0]), 96'(3'd0));
    step(4'b0001, 8'h00, 3'b000);
    drain(10);

    // Order on bank 1: ch0, ch2, ch0.
    step(4'b0010, 8'h00, 3'b000);
    step(4'b0010, 8'h08, 3'b000);
    step(4'b0010, 8'h00, 3'b000);
    for (int i = 0; i < 3; i++) step(4'b0000, 8'h00, 3'b101);

    // Round-robin: every bank holds two channel-2 entries.
    step(4'hF, 8'hAA, 3'b000);
    step(4'hF, 8'hAA, 3'b000);
    for (int i = 0; i < 10; i++) step(4'h0, 8'h00, 3'b100);

    // Bank 3 write concurrent with two releases from bank 3.
    step(4'b1000, 8'h00, 3'b000);
    step(4'b1000, 8'h40, 3'b000);
    step(4'b1000, 8'h80, 3'b000);
    step(4'b1000, 8'h00, 3'b011);
    drain(6);

    // Reset with five entries pending.
    step(4'hF, 8'h00, 3'b000);
    step(4'b0001, 8'h00, 3'b000);
    do_reset();
    step(4'b0001, 8'h00, 3'b000);
    drain(4);

    // Randomized traffic, including the occasional illegal channel id.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        rch[2*b +: 2] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rready = ((i / 200) % 2 == 0) ? 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7))
                                    : 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
      step(4'($urandom_range(0, 15)), rch, rready);
    end
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rtn_xbar_ctrl.md
# rtn_xbar_ctrl

Control stage for the return crossbar. It accepts bank response handshakes and allocates a free entry in the per-bank 8-entry response buffer. It keeps per-(bank, channel) arrival order and arbitrates each channel across the four banks. It drives the buffer's write pointers and one-hot read selects, the bank-side `ready` signals and the channel-side `valid` signals. It sits beside the response-data buffer and fully controls it; data and rob_id never pass through this block.

## Interface
- `Cfg`, default `'0`: `mpc_cfg_t` configuration. It is carried for uniformity; geometry comes from package constants.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `d_bank_rsp_valid`  in  4  per-bank response valid; bit b is bank b.
- `d_bank_rsp_channel_id`  in  8  destination channel; bits [2b+1:2b] belong to bank b.
- `d_bank_rsp_ready`  out  4  per-bank ready; bank b has a free entry.
- `bank_w_ptr`  out  12  write entry index; bits [3b+2:3b] belong to bank b.
- `u_ch_rsp_ready`  in  3  per-channel ready.
- `u_ch_rsp_valid`  out  3  per-channel valid.
- `ch_bank_1hot_id`  out  12  granted bank, one-hot; bits [4j+3:4j] belong to channel j.
- `bank_ch_r_entry_1hot_id`  out  96  read entry, one-hot; bits [8(3b+j)+7 : 8(3b+j)] belong to bank b, channel j.

## Operation
- **Handshakes.**
  - A bank handshake is `hs_b = valid[b] & ready[b]`.
  - A channel handshake is `cs_j = u_ch_rsp_valid[j] & u_ch_rsp_ready[j]`.
- **Per-bank state.**
  - Entry valid vector `ev[7:0]`.
  - Occupancy counter `cnt[3:0]`, range 0..8.
  - Three channel FIFOs of 3-bit entry indices, 8 deep each, with 3-bit read/write pointers and a 4-bit count.
- **Allocation.**
  - `bank_w_ptr[b]` is the lowest index with `ev=0`, or 0 when the bank is full.
  - `d_bank_rsp_ready[b] = (cnt != 8)`; it is a function of registered state only.
  - On `hs_b` with channel id c in {0,1,2}: set `ev[w_ptr]`, push w_ptr into FIFO c, and increment `cnt`.
- **Illegal channel id.** On `hs_b` with channel id 3, the handshake completes but nothing is allocated. The buffer overwrites a free entry, which is harmless.
- **Read select.** `bank_ch_r_entry_1hot_id[b][j]` is the one-hot of the head of FIFO (b,j) when that FIFO is non-empty, else 0.
- **Channel arbitration.**
  - Request vector: `req_j[b]` = FIFO (b,j) non-empty.
  - Each channel has its own round-robin arbiter with a 2-bit last-grant pointer, reset to 3, so bank 0 has first priority.
  - `ch_bank_1hot_id[j]` is the grant, or 0 when there is no request.
  - `u_ch_rsp_valid[j] = |req_j`; it never depends on `u_ch_rsp_ready`.
- **Release.** On `cs_j` with grant bank g:
  - pop FIFO (g,j);
  - clear the `ev` bit of the popped entry;
  - decrement `cnt[g]`;
  - set the last-grant pointer of channel j to g.
- **Simultaneous events.**
  - A bank write and a release in the same cycle are always to different entries, because allocation only picks free entries. `cnt` stays unchanged.
  - Up to 3 channels may release entries of the same bank in one cycle. `cnt` drops by the number of releases; the bank write may add 1 in the same cycle.
- **Reset.** Reset mid-operation drops every in-flight entry. No state survives.

## Timing
- Reset values of outputs:
  - `d_bank_rsp_ready = 4'hF`
  - `bank_w_ptr = 0`
  - `u_ch_rsp_valid = 0`
  - `ch_bank_1hot_id = 0`
  - `bank_ch_r_entry_1hot_id = 0`
- **Write-to-read latency.** An entry written at edge N is presented at the channel in cycle N+1. Minimum bank-to-channel latency is 1 cycle. There is no same-cycle bypass, because buffer data is registered.
- **Reuse of a freed entry.** An entry freed at edge N may be reallocated in cycle N+1. A full bank's `ready` rises in the cycle after the first release.
- **Throughput.** One accept per bank per cycle and one delivery per channel per cycle, sustained.
- **Ordering.**
  - Per (bank, channel): strict FIFO order.
  - Across banks within a channel: round-robin. No bank starves while its FIFO is non-empty; the maximum wait is 3 grants.

## Configuration
- `RTN_XBAR_CTRL_ASSERT_EN`: compiles in SVA checks:
  - no handshake with channel id 3;
  - `cnt <= 8`;
  - each grant is one-hot or zero;
  - `ev` popcount equals `cnt`;
  - a release only ever hits an `ev=1` entry.
- Without the macro there are no checks, and the behaviour is identical.

## Structure
- `mpc_types` holds:
  - `RTN_NBANK=4`, `RTN_NCH=3`, `RTN_NENTRY=8`;
  - `typedef logic [2:0] rtnEntry_t`;
  - `typedef logic [1:0] rtnCh_t`.
- Sub-module `rtn_xbar_ctrl_bank`: one instance per bank. It contains the allocator, `ev`, `cnt` and the three channel FIFOs. Its inputs are `hs`, channel id and per-channel pop; its outputs are `ready`, `w_ptr`, per-channel non-empty flags and the head one-hots.
- The top level holds the three round-robin arbiters and the port slicing.

## Test plan
- **Single response.** Bank 2 sends one response with ch=1, with `u_ch_rsp_ready` held at 0.
  - `bank_w_ptr[2]=0`.
  - The cycle after, `u_ch_rsp_valid=3'b010`, `ch_bank_1hot_id[1]=4'b0100`, and `r_entry_1hot[2][1]=8'h01`.
  - Raising ready releases the entry.
- **Fill and backpressure.** Bank 0 receives 9 consecutive valids for ch=0, with channel ready at 0.
  - The first 8 are accepted at `w_ptr` 0..7.
  - `ready[0]=0` from cycle 8 on.
  - One release raises `ready[0]` the next cycle, and the refill uses the freed index.
- **Order.** Bank 1 sends ch0, ch2, ch0 into entries 0,1,2.
  - Channel 0 receives entry 0, then entry 2.
  - Channel 2 receives entry 1.
- **Round-robin.** All 4 banks hold 2 entries each for ch=2, and ready is held at 1.
  - The grant sequence is banks 0,1,2,3,0,1,2,3.
  - Valid drops after 8 cycles.
- **Simultaneous events.** In the same cycle, bank 3 writes a new entry while channels 0 and 1 both release bank-3 entries.
  - `cnt` goes 3→2.
  - No entry is lost or duplicated.
- **Reset mid-traffic.** Assert `rst_n` low while 5 entries are pending.
  - All outputs return to their reset values.
  - The first post-reset response lands at `w_ptr=0`.
